pkt_framer: RTL and testbench

PKT_FRAMER -- requirements
Module: pkt_framer

---
 rtl/pkt_framer.sv | 158 +++++++++++++++
 tb/tb_pkt_framer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_framer.sv
// Packet framer: registers each accepted flit and tags it with head/tail/format framing.
// Optional build macro PKT_ID_CHECK_EN adds per-packet vc/id/req consistency checking (err_id).
module pkt_framer #(
    parameter bit ZERO_LEN_MAX = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [39:0] in_flit,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [39:0] out_flit,
    output logic        out_head,
    output logic        out_tail,
    output logic [3:0]  out_fmt,
    output logic        err_fmt,
    output logic        err_id
);

    localparam logic [3:0] FmtLongRead   = 4'd0;
    localparam logic [3:0] FmtLongWrite  = 4'd1;
    localparam logic [3:0] FmtMemResp    = 4'd2;
    localparam logic [3:0] FmtMsg        = 4'd3;
    localparam logic [3:0] FmtShortWrite = 4'd6;

    typedef enum logic {StHead, StBody} state_e;

    state_e      state_q, state_d;
    logic [7:0]  rem_q, rem_d;
    logic [3:0]  fmt_q, fmt_d;
    logic        out_valid_q, out_valid_d;
    logic [39:0] out_flit_q, out_flit_d;
    logic        out_head_q, out_head_d;
    logic        out_tail_q, out_tail_d;
    logic [3:0]  out_fmt_q, out_fmt_d;
    logic        err_fmt_q, err_fmt_d;

    logic [3:0]  hdr_fmt;
    logic [7:0]  len7_words, len4_words, hdr_words;
    logic        xfer_in;

`ifdef PKT_ID_CHECK_EN
    logic [7:0]  tag_q, tag_d;
    logic        err_id_q, err_id_d;
`endif

    // Total packet length in words, decoded from a header flit.
    always_comb begin
        hdr_fmt    = in_flit[31:28];
        len7_words = (ZERO_LEN_MAX && in_flit[6:0] == 7'd0) ? 8'd128 : {1'b0, in_flit[6:0]};
        len4_words = (ZERO_LEN_MAX && in_flit[3:0] == 4'd0) ? 8'd16 : {4'd0, in_flit[3:0]};
        case (hdr_fmt)
            FmtLongRead:   hdr_words = 8'd2;
            FmtLongWrite:  hdr_words = 8'd2 + len7_words;
            FmtMemResp:    hdr_words = 8'd1 + len7_words;
            FmtMsg:        hdr_words = 8'd1 + len7_words;
            FmtShortWrite: hdr_words = 8'd1 + len4_words;
            default:       hdr_words = 8'd1;
        endcase
    end

    always_comb begin
        in_ready    = !out_valid_q || out_ready;
        xfer_in     = in_valid && in_ready;
        state_d     = state_q;
        rem_d       = rem_q;
        fmt_d       = fmt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_flit_d  = out_flit_q;
        out_head_d  = out_head_q;
        out_tail_d  = out_tail_q;
        out_fmt_d   = out_fmt_q;
        err_fmt_d   = 1'b0;
`ifdef PKT_ID_CHECK_EN
        tag_d       = tag_q;
        err_id_d    = 1'b0;
`endif
        if (xfer_in) begin
            out_valid_d = 1'b1;
            out_flit_d  = in_flit;
            if (state_q == StHead) begin
                out_head_d = 1'b1;
                out_fmt_d  = hdr_fmt;
                rem_d      = hdr_words - 8'd1;
                err_fmt_d  = hdr_fmt > FmtShortWrite;
                if (hdr_words == 8'd1) begin
                    out_tail_d = 1'b1;
                end else begin
                    out_tail_d = 1'b0;
                    state_d    = StBody;
                    fmt_d      = hdr_fmt;
`ifdef PKT_ID_CHECK_EN
                    tag_d      = in_flit[39:32];
`endif
                end
            end else begin
                out_head_d = 1'b0;
                out_fmt_d  = fmt_q;
                rem_d      = rem_q - 8'd1;
                out_tail_d = rem_q == 8'd1;
                if (rem_q == 8'd1) begin
                    state_d = StHead;
                end
`ifdef PKT_ID_CHECK_EN
                err_id_d = in_flit[39:32] != tag_q;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StHead;
            rem_q       <= 8'd0;
            fmt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            out_flit_q  <= 40'd0;
            out_head_q  <= 1'b0;
            out_tail_q  <= 1'b0;
            out_fmt_q   <= 4'd0;
            err_fmt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            fmt_q       <= fmt_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_head_q  <= out_head_d;
            out_tail_q  <= out_tail_d;
            out_fmt_q   <= out_fmt_d;
            err_fmt_q   <= err_fmt_d;
        end
    end

`ifdef PKT_ID_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q    <= 8'd0;
            err_id_q <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            err_id_q <= err_id_d;
        end
    end
    assign err_id = err_id_q;
`else
    assign err_id = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign out_head  = out_head_q;
    assign out_tail  = out_tail_q;
    assign out_fmt   = out_fmt_q;
    assign err_fmt   = err_fmt_q;

endmodule

// File: tb/tb_pkt_framer.sv
// Self-checking bench for pkt_framer: constant vector table, directed corner sequences and
// randomized traffic against a packet-level reference model.
module tb_pkt_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [39:0] in_flit = 40'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [39:0] out_flit;
    logic        out_head;
    logic        out_tail;
    logic [3:0]  out_fmt;
    logic        err_fmt;
    logic        err_id;

    pkt_framer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_flit   (in_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_flit  (out_flit),
        .out_head  (out_head),
        .out_tail  (out_tail),
        .out_fmt   (out_fmt),
        .err_fmt   (err_fmt),
        .err_id    (err_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: expected output register and position inside the current packet.
    logic        exp_valid, exp_head, exp_tail, exp_err_fmt, exp_err_id;
    logic [39:0] exp_flit;
    logic [3:0]  exp_fmt;
    int          words_left;
    logic [3:0]  pkt_fmt;
    logic [7:0]  pkt_tag;
    logic        last_xfer;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int packet_words(input logic [31:0] p);
        int l7, l4;
        l7 = (p[6:0] == 0) ? 128 : int'(p[6:0]);
        l4 = (p[3:0] == 0) ? 16 : int'(p[3:0]);
        case (int'(p[31:28]))
            0:       return 2;
            1:       return 2 + l7;
            2, 3:    return 1 + l7;
            6:       return 1 + l4;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        exp_valid = 0; exp_head = 0; exp_tail = 0; exp_err_fmt = 0; exp_err_id = 0;
        exp_flit = 40'd0; exp_fmt = 4'd0; words_left = 0; pkt_fmt = 4'd0; pkt_tag = 8'd0;
    endtask

    task automatic model_step(input logic xfer, input logic [39:0] f, input logic r);
        int n;
        exp_err_fmt = 0;
        exp_err_id  = 0;
        if (exp_valid && r) exp_valid = 0;
        if (xfer) begin
            exp_valid = 1;
            exp_flit  = f;
            if (words_left == 0) begin
                n           = packet_words(f[31:0]);
                exp_head    = 1;
                exp_tail    = (n == 1);
                exp_fmt     = f[31:28];
                exp_err_fmt = (f[31:28] >= 4'd7);
                words_left  = n - 1;
                pkt_fmt     = f[31:28];
                pkt_tag     = f[39:32];
            end else begin
                exp_head   = 0;
                exp_fmt    = pkt_fmt;
                words_left = words_left - 1;
                exp_tail   = (words_left == 0);
`ifdef PKT_ID_CHECK_EN
                exp_err_id = (f[39:32] != pkt_tag);
`endif
            end
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", {39'd0, out_valid}, {39'd0, exp_valid});
        if (exp_valid) begin
            chk("out_flit", out_flit, exp_flit);
            chk("out_head", {39'd0, out_head}, {39'd0, exp_head});
            chk("out_tail", {39'd0, out_tail}, {39'd0, exp_tail});
            chk("out_fmt", {36'd0, out_fmt}, {36'd0, exp_fmt});
        end
        chk("err_fmt", {39'd0, err_fmt}, {39'd0, exp_err_fmt});
        chk("err_id", {39'd0, err_id}, {39'd0, exp_err_id});
    endtask

    // One clock: drive inputs, check in_ready, advance model, check registered outputs.
    task automatic cycle(input logic v, input logic [39:0] f, input logic r);
        logic rdy;
        in_valid  = v;
        in_flit   = f;
        out_ready = r;
        #1;
        rdy = !exp_valid || r;
        chk("in_ready", {39'd0, in_ready}, {39'd0, rdy});
        last_xfer = v && rdy;
        model_step(last_xfer, f, r);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_valid", {39'd0, out_valid}, 40'd0);
        chk("rst_out_flit", out_flit, 40'd0);
        chk("rst_out_head", {39'd0, out_head}, 40'd0);
        chk("rst_out_tail", {39'd0, out_tail}, 40'd0);
        chk("rst_out_fmt", {36'd0, out_fmt}, 40'd0);
        chk("rst_err_fmt", {39'd0, err_fmt}, 40'd0);
        chk("rst_err_id", {39'd0, err_id}, 40'd0);
        chk("rst_in_ready", {39'd0, in_ready}, 40'd1);
    endtask

    // Asserted between clock edges so the clear must come from the asynchronous path.
    task automatic apply_reset();
        in_valid  = 0;
        out_ready = 0;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs();
    endtask

    typedef struct {
        logic        v;
        logic [39:0] f;
        logic        r;
        logic        ev;
        logic        eh;
        logic        et;
        logic [3:0]  efmt;
        logic        eerr;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int tail_at;
        logic [39:0] pend;
        logic        have_pend;

        tbl[0]  = '{1'b1, 40'h00_5000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0};
        tbl[1]  = '{1'b1, 40'h00_C000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'hC, 1'b1};
        tbl[2]  = '{1'b1, 40'h00_0000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};
        tbl[3]  = '{1'b1, 40'h00_1234_5678, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0};
        tbl[4]  = '{1'b0, 40'h00_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
        tbl[5]  = '{1'b1, 40'h00_6000_0002, 1'b1, 1'b1, 1'b1, 1'b0, 4'h6, 1'b0};
        tbl[6]  = '{1'b1, 40'h00_AAAA_AAAA, 1'b1, 1'b1, 1'b0, 1'b0, 4'h6, 1'b0};
        tbl[7]  = '{1'b1, 40'h00_0000_0001, 1'b1, 1'b1, 1'b0, 1'b1, 4'h6, 1'b0};
        tbl[8]  = '{1'b1, 40'h00_4FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1, 4'h4, 1'b0};
        tbl[9]  = '{1'b1, 40'h00_7000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'h7, 1'b1};
        tbl[10] = '{1'b0, 40'h00_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};

        model_reset();
        #2;
        apply_reset();

        // Constant vector table.
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].v, tbl[i].f, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), {39'd0, out_valid}, {39'd0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_head", i), {39'd0, out_head}, {39'd0, tbl[i].eh});
                chk($sformatf("tbl%0d_tail", i), {39'd0, out_tail}, {39'd0, tbl[i].et});
                chk($sformatf("tbl%0d_fmt", i), {36'd0, out_fmt}, {36'd0, tbl[i].efmt});
            end
            chk($sformatf("tbl%0d_errfmt", i), {39'd0, err_fmt}, {39'd0, tbl[i].eerr});
        end

        // LONG_WRITE length 3: five back-to-back words.
        cycle(1, 40'h00_1000_0003, 1);
        for (int i = 0; i < 4; i++) cycle(1, 40'h00_0000_1000 + 40'(i), 1);
        chk("lw_tail_last", {39'd0, out_tail}, 40'd1);

        // MSG length 0 -> 129 words; tail position measured from the DUT.
        tail_at = 0;
        cycle(1, 40'h00_3000_0000, 1);
        for (int i = 2; i <= 140 && tail_at == 0; i++) begin
            cycle(1, 40'h00_0000_0000 + 40'(i), 1);
            if (out_tail) tail_at = i;
        end
        chk("msg_tail_word", 40'(tail_at), 40'd129);
        cycle(1, 40'h00_5000_0000, 1);
        chk("msg_next_head", {39'd0, out_head}, 40'd1);

        // MEM_RESP with a 3-cycle output stall.
        cycle(1, 40'h00_2000_0004, 1);
        cycle(1, 40'h00_0000_0B01, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 40'h00_0000_0B02, 0);
            chk("stall_in_ready", {39'd0, in_ready}, 40'd0);
        end
        cycle(1, 40'h00_0000_0B02, 1);
        cycle(1, 40'h00_0000_0B03, 1);
        cycle(1, 40'h00_0000_0B04, 1);
        chk("stall_tail", {39'd0, out_tail}, 40'd1);
        cycle(0, 40'd0, 1);

        // Reset after word 2 of a 5-word packet, then a fresh SHORT_WRITE packet.
        cycle(1, 40'h00_1000_0003, 1);
        cycle(1, 40'h00_0000_0C01, 1);
        #2;
        apply_reset();
        cycle(1, 40'h00_6000_0002, 1);
        chk("rst_hdr_head", {39'd0, out_head}, 40'd1);
        cycle(1, 40'h5A_0000_0C02, 1);
        cycle(1, 40'h00_0000_0C03, 1);
        chk("rst_sw_tail", {39'd0, out_tail}, 40'd1);
        cycle(0, 40'd0, 1);

        // Randomized traffic.
        have_pend = 0;
        pend = 40'd0;
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] p;
            logic [6:0]  len;
            if (!have_pend) begin
                p = $urandom;
                if (words_left == 0) begin
                    len = ($urandom_range(0, 15) == 0) ? 7'd0 : 7'($urandom_range(1, 6));
                    p[31:28] = 4'($urandom_range(0, 15));
                    p[6:0]   = len;
                    pend = {8'($urandom), p};
                end else begin
                    pend = {($urandom_range(0, 9) == 0) ? 8'($urandom) : pkt_tag, p};
                end
                have_pend = 1;
            end
            cycle($urandom_range(0, 3) != 0, pend, $urandom_range(0, 3) != 0);
            if (last_xfer) have_pend = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
